mod_addsub_array: RTL and testbench
===================================

Name: mod_addsub_array

Overview:
- Parametrised, multi-lane modular add/subtract engine for the curve datapath; successor to the fixed-width single-op add/sub units used inside point arithmetic.
- Each lane performs ADD, SUB, NEG or DBL mod P on W-bit operands.
- Two-stage pipeline with valid/ready handshake, backpressure and a sideband tag.
- Point-operation sequencers issue all lanes of one step in a single transfer.

Parameters:
- W, 255, operand/result width in bits.
- LANES, 2, number of independent lanes per transfer.
- P, 2^255-19, modulus (W-bit constant, P < 2^W).
- TAG_W, 4, width of the sideband tag carried with each transfer.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input transfer valid
- o_ready  out  1  engine can accept a transfer this cycle
- i_op  in  2*LANES  per-lane op, lane k at [2k+1:2k]: 0=ADD, 1=SUB, 2=NEG, 3=DBL
- i_a  in  W*LANES  per-lane operand A, lane k at [W*k+W-1:W*k]
- i_b  in  W*LANES  per-lane operand B (ignored for NEG and DBL)
- i_tag  in  TAG_W  sideband tag, returned unchanged with the result
- o_valid  out  1  result transfer valid
- i_ready  in  1  downstream accepts the result
- o_result  out  W*LANES  per-lane reduced result, same packing as i_a
- o_tag  out  TAG_W  tag of the current result
- o_busy  out  1  either pipeline stage holds valid data

Behaviour:
- Reset: async, active-high. Clears the s1/s2 valid bits; o_valid=0, o_busy=0, o_ready=1, o_result=0, o_tag=0. Data registers may also clear.
- Reset mid-operation: in-flight transfers are discarded, never emitted. The first accept after reset deassertion is treated as fresh.
- Handshake:
  - Input accepted when i_valid && o_ready.
  - Output consumed when o_valid && i_ready.
  - adv2 = !s2_valid || i_ready; adv1 = !s1_valid || adv2; o_ready = adv1 (combinational from i_ready).
- While o_valid=1 && i_ready=0: o_result/o_tag are held stable.
- Stage 1 (on accept), per lane, W+1-bit raw value plus op:
  - ADD: a+b
  - SUB: a-b (two's complement; bit W = borrow)
  - NEG: 0-a
  - DBL: a+a
- Stage 2 (on adv2), single correction:
  - ADD/DBL: raw>=P ? raw-P : raw
  - SUB/NEG: borrow ? raw+P : raw
  - Result truncated to W bits.
- Latency: 2 cycles accept-to-o_valid with no stall. Throughput 1 transfer/cycle while i_ready=1.
- Ordering: strictly in order; at most 2 transfers in flight.
- Boundaries:
  - NEG of 0 gives 0; SUB a==b gives 0; ADD a+b==P gives 0.
  - All-full with i_ready=0: o_ready=0 and nothing advances. Next cycle with i_ready=1: both stages shift and a new input is accepted in the same cycle.
  - Simultaneous accept and emit is legal every cycle.
- Operands must be < P. Inputs ≥ P are not detected; the result is the single-correction value.
- o_busy = s1_valid | s2_valid.

Decomposition:
- Package mod_arith_pkg:
  - op typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_NEG, OP_DBL}
  - default-modulus localparam P_25519
  - W default constant
- Sub-module mod_addsub_lane (one lane's stage-1/stage-2 data registers and correction logic, enables from the top). The top instantiates LANES copies via generate and owns the valid/ready control and tag pipeline.

Test Plan:
- Lane ops, default P: ADD a=P-1,b=2 → 1; SUB a=0,b=1 → P-1; NEG a=5 → P-5; NEG a=0 → 0; DBL a=P-1 → P-2; ADD a=7,b=P-7 → 0. Each o_valid exactly 2 cycles after accept with the matching tag.
- Streaming: 8 back-to-back transfers, tags 0..7, i_ready=1. o_valid high for 8 consecutive cycles starting at cycle 2, tags 0..7 in order, o_ready never drops.
- Backpressure: issue tags 1,2,3 back-to-back with i_ready=0. Tags 1,2 accepted, o_ready=0 on the third; o_result/o_tag stay at tag 1 and stable. Raise i_ready: tag 3 accepted that cycle, outputs 1,2,3 in order, none lost or duplicated.
- Mixed lanes, LANES=2: lane0 SUB 3-5, lane1 ADD 3+5 in one transfer → P-2 and 8 in the same beat.
- Reset mid-flight: accept 2 transfers, assert i_rst asynchronously between clock edges. o_valid/o_busy drop immediately and o_ready=1. After release no stale result appears; a new transfer returns correctly after 2 cycles.
- Small-modulus sweep, W=4, P=13: exhaustive a,b in 0..12 for all 4 ops against a reference model (e.g. SUB 2-9 → 6, DBL 12 → 11).

Source files
------------

// File: rtl/mod_arith_pkg.sv
// Shared types and constants for the modular add/sub datapath.
// Op encoding, default width and the default curve modulus.
package mod_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_NEG = 2'd2,
    OP_DBL = 2'd3
  } op_e;

  localparam int W_DEFAULT     = 255;
  localparam int LANES_DEFAULT = 2;
  localparam int TAG_W_DEFAULT = 4;

  // 2^255 - 19
  localparam logic [W_DEFAULT-1:0] P_25519 =
    {W_DEFAULT{1'b1}} - W_DEFAULT'(18);

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane: stage-1 raw add/sub register, stage-2 reduced result.
// Ports: clk_i, rst_i, ld1_i/ld2_i stage enables, op_i, a_i, b_i, res_o.
module mod_addsub_lane
  import mod_arith_pkg::*;
#(
  parameter int            W = W_DEFAULT,
  parameter logic [W-1:0]  P = W'(P_25519)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld1_i,
  input  logic         ld2_i,
  input  op_e          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o
);

  logic [W:0]   raw_d, raw_q;
  op_e          op_q;
  logic [W-1:0] res_d, res_q;

  // Bit W of raw is the carry for ADD/DBL and the borrow for SUB/NEG.
  always_comb begin
    raw_d = '0;
    case (op_i)
      OP_ADD:  raw_d = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  raw_d = {1'b0, a_i} - {1'b0, b_i};
      OP_NEG:  raw_d = (W+1)'(0) - {1'b0, a_i};
      OP_DBL:  raw_d = {a_i, 1'b0};
      default: raw_d = '0;
    endcase
  end

  // Single correction; the low W bits of raw -/+ P are exact mod 2^W.
  always_comb begin
    res_d = raw_q[W-1:0];
    case (op_q)
      OP_ADD, OP_DBL:
        if (raw_q >= {1'b0, P}) res_d = raw_q[W-1:0] - P;
      OP_SUB, OP_NEG:
        if (raw_q[W]) res_d = raw_q[W-1:0] + P;
      default: res_d = raw_q[W-1:0];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      raw_q <= '0;
      op_q  <= OP_ADD;
      res_q <= '0;
    end else begin
      if (ld1_i) begin
        raw_q <= raw_d;
        op_q  <= op_i;
      end
      if (ld2_i) res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/mod_addsub_array.sv
// Multi-lane modular add/sub engine, 2-stage valid/ready pipeline.
// Ports: i_clk, i_rst, i_valid/o_ready in, o_valid/i_ready out,
//        i_op, i_a, i_b, i_tag, o_result, o_tag, o_busy.
module mod_addsub_array
  import mod_arith_pkg::*;
#(
  parameter int           W     = W_DEFAULT,
  parameter int           LANES = LANES_DEFAULT,
  parameter logic [W-1:0] P     = W'(P_25519),
  parameter int           TAG_W = TAG_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2*LANES-1:0] i_op,
  input  logic [W*LANES-1:0] i_a,
  input  logic [W*LANES-1:0] i_b,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [W*LANES-1:0] o_result,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_busy
);

  logic             s1_vld_q, s1_vld_d;
  logic             s2_vld_q, s2_vld_d;
  logic [TAG_W-1:0] tag1_q, tag2_q;
  logic             adv1, adv2, acc, ld2;

  assign adv2    = !s2_vld_q || i_ready;
  assign adv1    = !s1_vld_q || adv2;
  assign o_ready = adv1;
  assign acc     = i_valid && adv1;
  assign ld2     = adv2 && s1_vld_q;

  assign s1_vld_d = adv1 ? acc : s1_vld_q;
  assign s2_vld_d = adv2 ? s1_vld_q : s2_vld_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      tag1_q   <= '0;
      tag2_q   <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (acc) tag1_q <= i_tag;
      if (ld2) tag2_q <= tag1_q;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mod_addsub_lane #(
      .W (W),
      .P (P)
    ) u_lane (
      .clk_i (i_clk),
      .rst_i (i_rst),
      .ld1_i (acc),
      .ld2_i (ld2),
      .op_i  (op_e'(i_op[2*k +: 2])),
      .a_i   (i_a[W*k +: W]),
      .b_i   (i_b[W*k +: W]),
      .res_o (o_result[W*k +: W])
    );
  end

  assign o_valid = s2_vld_q;
  assign o_tag   = tag2_q;
  assign o_busy  = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_mod_addsub_array.sv
// Directed bench for mod_addsub_array: default P engine plus a
// W=4, P=13 instance swept exhaustively against an integer model.
module tb_mod_addsub_array;

  localparam logic [254:0] PB = ~255'd18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         valid = 1'b0, rdy_in = 1'b1;
  logic         o_ready, o_valid, o_busy;
  logic [3:0]   op = '0;
  logic [509:0] a = '0, b = '0, result;
  logic [3:0]   tag = '0, otag;

  logic         s_valid = 1'b0, s_rdy_in = 1'b1;
  logic         s_ready, s_ovalid, s_busy;
  logic [3:0]   s_op = '0;
  logic [7:0]   s_a = '0, s_b = '0, s_res;
  logic [8:0]   s_tag = '0, s_otag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_addsub_array dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
    .i_op(op), .i_a(a), .i_b(b), .i_tag(tag), .o_valid(o_valid),
    .i_ready(rdy_in), .o_result(result), .o_tag(otag), .o_busy(o_busy)
  );

  mod_addsub_array #(
    .W(4), .LANES(2), .P(4'd13), .TAG_W(9)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready),
    .i_op(s_op), .i_a(s_a), .i_b(s_b), .i_tag(s_tag),
    .o_valid(s_ovalid), .i_ready(s_rdy_in), .o_result(s_res),
    .o_tag(s_otag), .o_busy(s_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref13(int o, int x, int y);
    case (o)
      0:       return (x + y) % 13;
      1:       return (x - y + 13) % 13;
      2:       return (13 - x) % 13;
      default: return (2 * x) % 13;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({o_valid, o_busy, o_ready, otag, result} !== {3'b001, 4'd0, 510'd0}) begin
      errors++;
      $display("FAIL reset: v/b/r=%b%b%b tag=%0d res=%h want 001 0 0",
               o_valid, o_busy, o_ready, otag, result);
    end
    checks++;
    if ({s_ovalid, s_busy, s_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_small: v/b/r=%b%b%b want 001",
               s_ovalid, s_busy, s_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_lane_ops();
    logic [1:0]   v_op [6];
    logic [254:0] v_a [6], v_b [6], v_e [6];
    v_op = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    v_a  = '{PB - 255'd1, 255'd0, 255'd5, 255'd0, PB - 255'd1, 255'd7};
    v_b  = '{255'd2, 255'd1, 255'd0, 255'd0, 255'd0, PB - 255'd7};
    v_e  = '{255'd1, PB - 255'd1, PB - 255'd5, 255'd0, PB - 255'd2, 255'd0};
    for (int i = 0; i < 6; i++) begin
      int j;
      logic [3:0] t;
      j = 5 - i;
      t = 4'(i + 3);
      op = {v_op[j], v_op[i]};
      a = {v_a[j], v_a[i]};
      b = {v_b[j], v_b[i]};
      tag = t;
      valid = 1'b1;
      rdy_in = 1'b1;
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL ops_ready[%0d]: got %b want 1", i, o_ready);
      end
      step();
      valid = 1'b0;
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL ops_early[%0d]: o_valid=%b want 0", i, o_valid);
      end
      step();
      checks++;
      if ({o_valid, otag, result} !== {1'b1, t, v_e[j], v_e[i]}) begin
        errors++;
        $display("FAIL ops[%0d]: v=%b tag=%0d res=%h want tag=%0d res=%h",
                 i, o_valid, otag, result, t, {v_e[j], v_e[i]});
      end
      step();
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL ops_late[%0d]: o_valid=%b want 0", i, o_valid);
      end
    end
  endtask

  task automatic test_mixed_lanes();
    op = 4'b00_01;
    a = {255'd3, 255'd3};
    b = {255'd5, 255'd5};
    tag = 4'd14;
    valid = 1'b1;
    rdy_in = 1'b1;
    step();
    valid = 1'b0;
    step();
    checks++;
    if ({o_valid, otag, result} !== {1'b1, 4'd14, 255'd8, PB - 255'd2}) begin
      errors++;
      $display("FAIL mixed: v=%b tag=%0d res=%h", o_valid, otag, result);
    end
    step();
  endtask

  task automatic test_back_to_back();
    rdy_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        op = 4'b01_00;
        a = {255'd0, 255'(c)};
        b = {255'(c), 255'd1};
        tag = 4'(c);
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: got %b want 1", c, o_ready);
      end
      if (c >= 2) begin
        logic [254:0] e1;
        e1 = (c == 2) ? 255'd0 : PB - 255'(c - 2);
        checks++;
        if ({o_valid, otag, result} !== {1'b1, 4'(c - 2), e1, 255'(c - 1)}) begin
          errors++;
          $display("FAIL stream[%0d]: v=%b tag=%0d res=%h want tag=%0d",
                   c, o_valid, otag, result, c - 2);
        end
      end else begin
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early[%0d]: o_valid=%b want 0", c, o_valid);
        end
      end
      step();
    end
    checks++;
    if ({o_valid, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL stream_drain: v/busy=%b%b want 00", o_valid, o_busy);
    end
  endtask

  task automatic test_backpressure();
    logic [509:0] e [4];
    for (int t = 1; t < 4; t++)
      e[t] = {PB - 255'(t), 255'(2 * t)};
    op = 4'b10_00;
    rdy_in = 1'b0;
    valid = 1'b1;
    for (int t = 1; t < 3; t++) begin
      a = {255'(t), 255'(t)};
      b = {255'd0, 255'(t)};
      tag = 4'(t);
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept[%0d]: o_ready=%b want 1", t, o_ready);
      end
      step();
    end
    a = {255'd3, 255'd3};
    b = {255'd0, 255'd3};
    tag = 4'd3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_ready, o_valid, otag, result} !== {2'b01, 4'd1, e[1]}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rdy=%b v=%b tag=%0d res=%h want 0 1 1 %h",
                 k, o_ready, o_valid, otag, result, e[1]);
      end
      step();
    end
    rdy_in = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: o_ready=%b want 1", o_ready);
    end
    checks++;
    if ({o_valid, otag, result} !== {1'b1, 4'd1, e[1]}) begin
      errors++;
      $display("FAIL bp_out1: v=%b tag=%0d res=%h", o_valid, otag, result);
    end
    step();
    valid = 1'b0;
    for (int t = 2; t < 4; t++) begin
      checks++;
      if ({o_valid, otag, result} !== {1'b1, 4'(t), e[t]}) begin
        errors++;
        $display("FAIL bp_out%0d: v=%b tag=%0d res=%h want %h",
                 t, o_valid, otag, result, e[t]);
      end
      step();
    end
    checks++;
    if ({o_valid, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL bp_drain: v/busy=%b%b want 00", o_valid, o_busy);
    end
  endtask

  task automatic test_reset_midflight();
    op = 4'b00_00;
    a = {255'd4, 255'd4};
    b = {255'd4, 255'd4};
    rdy_in = 1'b1;
    valid = 1'b1;
    tag = 4'd9;
    step();
    tag = 4'd10;
    step();
    valid = 1'b0;
    checks++;
    if ({o_valid, o_busy, otag} !== {2'b11, 4'd9}) begin
      errors++;
      $display("FAIL rst_pre: v/busy=%b%b tag=%0d want 11 9",
               o_valid, o_busy, otag);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_busy, o_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst_async: v/b/r=%b%b%b want 001",
               o_valid, o_busy, o_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_valid, o_busy} !== 2'b00) begin
        errors++;
        $display("FAIL rst_stale[%0d]: v/busy=%b%b want 00", k, o_valid, o_busy);
      end
      step();
    end
    op = 4'b11_00;
    a = {255'd4, 255'd1};
    b = {255'd0, 255'd2};
    tag = 4'd12;
    valid = 1'b1;
    step();
    valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_new_early: o_valid=%b want 0", o_valid);
    end
    step();
    checks++;
    if ({o_valid, otag, result} !== {1'b1, 4'd12, 255'd8, 255'd3}) begin
      errors++;
      $display("FAIL rst_new: v=%b tag=%0d res=%h", o_valid, otag, result);
    end
    step();
  endtask

  task automatic test_small_sweep();
    s_rdy_in = 1'b1;
    for (int c = 0; c < 340; c++) begin
      if (c < 338) begin
        int j0, j1;
        j0 = 2 * c;
        j1 = j0 + 1;
        s_op  = {2'(j1 / 169), 2'(j0 / 169)};
        s_a   = {4'((j1 % 169) / 13), 4'((j0 % 169) / 13)};
        s_b   = {4'(j1 % 13), 4'(j0 % 13)};
        s_tag = 9'(c);
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      if (c >= 2) begin
        int m, k0, k1, e0, e1;
        m  = c - 2;
        k0 = 2 * m;
        k1 = k0 + 1;
        e0 = ref13(k0 / 169, (k0 % 169) / 13, k0 % 13);
        e1 = ref13(k1 / 169, (k1 % 169) / 13, k1 % 13);
        checks++;
        if ({s_ovalid, s_otag, s_res} !== {1'b1, 9'(m), 4'(e1), 4'(e0)}) begin
          errors++;
          $display("FAIL sweep[%0d]: v=%b tag=%0d res=%h want tag=%0d res=%h%h",
                   m, s_ovalid, s_otag, s_res, m, 4'(e1), 4'(e0));
        end
      end
      step();
    end
    checks++;
    if ({s_ovalid, s_busy} !== 2'b00) begin
      errors++;
      $display("FAIL sweep_drain: v/busy=%b%b want 00", s_ovalid, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_lane_ops();
    test_mixed_lanes();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_small_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
